sqrt_f32_issue: RTL
===================

Name: sqrt_f32_issue

Overview:
Upstream issue stage for the iterative f32 square-root core (`squareroot_f32`).
- Accepts f32 operands on a valid/ready stream and buffers them in a small FIFO.
- Sequences the core one operand at a time: holds the operand, pulses the core reset, waits for the core's ready flag.
- Captures the result into a valid/ready output register.
- Bounds each operation with a cycle timeout, because the core's exact-equality convergence test may never fire.

Parameters:
- DEPTH, 4, operand FIFO entries; must be a power of 2 and ≥ 2.
- MAX_CYCLES, 256, timeout on core iteration, counted in WAIT cycles; minimum 8.
- WIDTH, 32, operand/result width; fixed at 32 (f32).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand present.
- in_ready  out  1  FIFO not full.
- in_data  in  32  f32 operand.
- out_valid  out  1  result held.
- out_ready  in  1  consumer accepts result.
- out_data  out  32  f32 result.
- out_timeout  out  1  result was taken on timeout, not convergence.
- core_rst  out  1  drives the core's rst.
- core_a  out  32  drives the core's a.
- core_rdy  in  1  core's rdy.
- core_sqrt  in  32  core's sqrt.

Behaviour:
- Reset values: in_ready=1 (FIFO empty), out_valid=0, out_data=0, out_timeout=0, core_rst=1, core_a=0, FIFO empty, counter=0, state=IDLE.
- Reset mid-operation: abandons the operand in flight and all FIFO contents; nothing is emitted.
- FIFO push: on in_valid && in_ready.
- in_ready = !full. A push while full is not accepted, even if a pop occurs in the same cycle.
- Push and pop in the same cycle on a non-full FIFO are both performed; occupancy is unchanged.
- Pointers are log2(DEPTH) bits wide and wrap naturally; occupancy counter is log2(DEPTH)+1 bits.
- State IDLE: core_rst=1. If the FIFO is non-empty, pop the head into the op register (drives core_a) and go to START.
- State START: one cycle with core_rst=1 so the core loads its initial state; core_a is already stable. Go to WAIT and clear the counter.
- State WAIT: core_rst=0, counter increments every cycle, core_a is held constant.
  - If core_rdy=1: out_data ← core_sqrt, out_timeout ← 0, go to DONE.
  - Else if counter == MAX_CYCLES-1: out_data ← core_sqrt, out_timeout ← 1, go to DONE.
  - core_rdy and the timeout in the same cycle: core_rdy wins, out_timeout=0.
- State DONE: out_valid=1, core_rst=1 (core parked). On out_ready, clear out_valid and go to IDLE. out_data and out_timeout remain stable while out_valid=1.
- core_rdy is sampled only in WAIT. Its value in every other state is ignored.
- Latency, FIFO empty and consumer ready:
  - Pop in IDLE on the cycle after the push.
  - One START cycle.
  - WAIT for the core's iteration count k.
  - out_valid the cycle after core_rdy is seen, i.e. push + 3 + k cycles.
- Throughput: one operation in flight. The next pop occurs in the IDLE cycle after the output handshake.
- Sign: passed through unchanged by the core. This block performs no NaN/negative checks.

Optional Feature:
- Macro: SQRT_ISSUE_ZERO_BYPASS_EN.
- When defined:
  - An operand whose exponent field is 0 (±0 or denormal) goes from IDLE directly to DONE.
  - out_data = {sign, 31'b0}, out_timeout=0.
  - The core is never released from reset for that operand.
  - out_valid is asserted 2 cycles after the push.
- When undefined: every operand goes through START/WAIT. A zero input typically exits via timeout.

Decomposition:
- Shared include sqrt_defs.vh:
  - State encodings: IDLE=2'd0, START=2'd1, WAIT=2'd2, DONE=2'd3.
  - F32 field widths: EXPONENTWIDTH=8, MANTISSAWIDTH=23.
  - Constant F32_TWO=32'h40000000.
- One sub-module: sync_fifo (parameters WIDTH, DEPTH; ports clk, rst, push, pop, din, dout, full, empty), with rst asynchronous and active-high.
- The control FSM, counter and output register live in sqrt_f32_issue.

Test Plan:
- Push 0x40800000 (4.0), out_ready=1, real core attached → out_data=0x40000000 (2.0), out_timeout=0; core_a stable throughout WAIT.
- Push 0x41800000 (16.0) then 0x40800000 back-to-back, out_ready=0 until the first result appears → results in order 0x40800000 then 0x40000000; the second is not popped before the first output handshake.
- Stub core with core_rdy stuck 0, MAX_CYCLES=64, push 0x40400000 → out_valid exactly 64 WAIT cycles after START, out_timeout=1, out_data=core_sqrt sampled on the last WAIT cycle.
- DEPTH=4, out_ready=0, push 6 operands on consecutive cycles → first is popped to the engine, next 4 fill the FIFO, in_ready=0 while the 6th is held; releasing out_ready drains all 6 in order.
- Assert rst during WAIT with 2 entries queued → out_valid=0, core_rst=1, in_ready=1 asynchronously; no stale result afterwards; a fresh push of 0x40800000 yields 0x40000000.
- With SQRT_ISSUE_ZERO_BYPASS_EN, push 0x80000000 → out_data=0x80000000 two cycles after the push, core_rst never deasserted.

Source files
------------

// File: rtl/sqrt_f32_issue_pkg.sv
// Shared definitions for the f32 square-root issue stage: FSM encodings,
// f32 field widths and constants.
package sqrt_f32_issue_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } state_e;

   localparam int EXPONENTWIDTH = 8;
   localparam int MANTISSAWIDTH = 23;
   localparam logic [31:0] F32_TWO = 32'h40000000;

   // True for +-0 and denormals, which the bypass path answers without the core.
   function automatic logic exp_zero(input logic [31:0] f);
      return f[MANTISSAWIDTH +: EXPONENTWIDTH] == '0;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous operand FIFO with natural-wrap pointers and an occupancy counter.
// A push while full is dropped even if a pop happens in the same cycle.
module sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [AW:0]      count;
   logic             do_push, do_pop;

   assign full    = count == (AW+1)'(DEPTH);
   assign empty   = count == '0;
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/sqrt_f32_issue.sv
// Issue stage for the iterative f32 square-root core: FIFO, core sequencing,
// timeout and result register. Optional macro: SQRT_ISSUE_ZERO_BYPASS_EN.
module sqrt_f32_issue
   import sqrt_f32_issue_pkg::*;
#(
   parameter int DEPTH      = 4,
   parameter int MAX_CYCLES = 256,
   parameter int WIDTH      = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_timeout,
   output logic             core_rst,
   output logic [WIDTH-1:0] core_a,
   input  logic             core_rdy,
   input  logic [WIDTH-1:0] core_sqrt
);

   localparam int CW = $clog2(MAX_CYCLES);

   state_e           state, state_nx;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] op, fifo_dout;
   logic             fifo_full, fifo_empty;
   logic             pop, zero_op, timeout_hit, wait_exit;

   sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (in_valid),
      .pop   (pop),
      .din   (in_data),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign in_ready    = !fifo_full;
   assign pop         = (state == IDLE) && !fifo_empty;
   assign timeout_hit = cnt == CW'(MAX_CYCLES - 1);
   assign wait_exit   = (state == WAIT) && (core_rdy || timeout_hit);
   assign core_a      = op;

`ifdef SQRT_ISSUE_ZERO_BYPASS_EN
   assign zero_op = exp_zero(fifo_dout);
`else
   assign zero_op = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:  if (pop) state_nx = zero_op ? DONE : START;
         START: state_nx = WAIT;
         WAIT:  if (core_rdy || timeout_hit) state_nx = DONE;
         DONE:  if (out_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // The core only runs in WAIT; every other state keeps it parked in reset.
   always_comb begin
      core_rst  = 1'b1;
      out_valid = 1'b0;
      case (state)
         WAIT:    core_rst  = 1'b0;
         DONE:    out_valid = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op          <= '0;
         cnt         <= '0;
         out_data    <= '0;
         out_timeout <= 1'b0;
      end else begin
         if (pop) op <= fifo_dout;
         if (state == START)     cnt <= '0;
         else if (state == WAIT) cnt <= cnt + 1'b1;
         // core_rdy takes priority over a coincident timeout
         if (wait_exit) begin
            out_data    <= core_sqrt;
            out_timeout <= !core_rdy;
         end
         if (pop && zero_op) begin
            out_data    <= {fifo_dout[WIDTH-1], {(WIDTH-1){1'b0}}};
            out_timeout <= 1'b0;
         end
      end
   end

endmodule
